dda_ctrl: RTL and testbench
===========================

Name: dda_ctrl

Overview:
- Upstream control/loader stage for the posit DDA core (spring-mass integrator pair).
- Accepts a byte-serial parameter stream from slow, asynchronous pins and assembles the five N-bit posit operands: ic1, ic2, vK_M, vD_M, dt.
- Commits the operands atomically, issues the core's gated initialisation cycle, then paces integration steps with a programmable prescaler.
- Drives the core's en and rst_n inputs; flags when v1/v2 are freshly updated for downstream sampling.

Parameters:
- N, 16, posit word width; must be a multiple of 8.
- ES, 2, posit exponent size; passed through for consistency, unused in logic.
- STEP_DIV, 4, clocks per integration step; minimum 2.
- CNT_W, 16, width of step_count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  8  parameter byte; must be stable while wr is high.
- wr  in  1  asynchronous byte strobe; the rising edge captures data_in.
- load_mode  in  1  asynchronous; a rising edge starts a load.
- hold  in  1  synchronous; pauses stepping while in RUN.
- ic1, ic2, vK_M, vD_M, dt  out  N each  committed operands to the core.
- dda_en  out  1  core enable.
- dda_rst_n  out  1  core's enable-gated synchronous reset.
- sample_valid  out  1  one-cycle pulse; v1/v2 updated.
- running  out  1  high in RUN.
- step_count  out  CNT_W  number of steps since the last INIT.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All operand outputs, step_count, byte counter, shadow registers and prescaler = 0.
  - dda_en=0, dda_rst_n=0, sample_valid=0, running=0.
- Input synchronisation:
  - wr and load_mode each pass through a 2-flop synchroniser plus an edge detector.
  - wr sampled high at edge k → byte written at edge k+2.
- States: IDLE, LOAD, INIT, RUN.
- IDLE:
  - Only a load_mode rising edge has effect → LOAD.
  - wr edges are ignored.
- LOAD:
  - Each wr rising edge writes data_in into the shadow byte at index byte_cnt, then byte_cnt++.
  - Byte order: ic1, ic2, vK_M, vD_M, dt; each word MSB byte first.
  - Total bytes = 5*N/8 (10 at N=16).
  - On the edge that writes the last byte: all five shadow words copy to the outputs, and state → INIT.
  - load_mode falling edge before completion → abort: state → IDLE, byte_cnt=0, outputs retain previous committed values.
  - If the last-byte write and a load_mode falling edge occur in the same cycle, completion wins.
- INIT (exactly one cycle):
  - dda_en=1, dda_rst_n=0, so the core loads ic1/ic2 at the end of this cycle.
  - step_count and prescaler cleared.
  - Next state is RUN.
  - dda_rst_n=1 from RUN entry onward; it returns to 0 only on async reset.
- RUN:
  - Prescaler counts 0..STEP_DIV-1.
  - dda_en=1 exactly in the cycle the count equals STEP_DIV-1; the counter then wraps to 0.
  - The first en pulse occurs STEP_DIV cycles after RUN entry.
  - sample_valid = dda_en delayed one cycle, and only for RUN pulses (not INIT).
  - step_count increments on each RUN en pulse and wraps modulo 2^CNT_W.
  - hold=1: prescaler frozen, dda_en=0; on release, counting resumes from the frozen value.
  - load_mode rising edge: → LOAD, byte_cnt=0, dda_en=0 in that cycle and thereafter. The operand outputs and the core state stay frozen until the next commit.
- All outputs are registered except running, which decodes from the state register.
- LOAD while operands are already committed: the outputs do not change until the full 5*N/8-byte set arrives.

Decomposition:
- Package dda_pkg:
  - State enum {IDLE, LOAD, INIT, RUN}.
  - NUM_WORDS=5.
  - Word index constants (IC1=0, IC2=1, KM=2, DM=3, DT=4).
  - BYTES_PER_WORD function of N.
- Sub-module sync_edge: 2-flop synchroniser with registered previous value. Outputs level, rise and fall. Instantiated for wr and for load_mode.

Test Plan:
- Load at N=16:
  - Stimulus: load_mode↑, then bytes 40 00, 00 00, 40 00, 38 00, 28 00.
  - Required: ic1=0x4000, ic2=0x0000, vK_M=0x4000, vD_M=0x3800, dt=0x2800.
  - INIT: one cycle with dda_en=1 and dda_rst_n=0.
  - First RUN dda_en 4 cycles later; sample_valid one cycle after that.
- Pacing: 20 clocks in RUN with hold=0 → exactly 5 dda_en pulses spaced 4 apart, step_count=5.
- Hold: hold=1 for 10 cycles mid-count → no dda_en; after release the next pulse arrives after the remaining count, not a full period.
- Abort: load_mode↓ after 6 bytes → state IDLE, outputs unchanged from the prior commit, no INIT pulse. A fresh load then starts again at ic1's MSB byte.
- Reload: load_mode↑ during RUN → dda_en stops within 3 cycles. A new 10-byte set commits atomically, then INIT resets step_count to 0.
- Reset: rst_n low mid-LOAD → all outputs 0 immediately (asynchronous); IDLE after release; wr edges ignored until load_mode↑.

Source files
------------

// File: rtl/dda_pkg.sv
// Shared types and constants for the posit DDA control/loader stage.
package dda_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    INIT = 2'd2,
    RUN  = 2'd3
  } state_e;

  localparam int NUM_WORDS = 5;

  localparam int IC1 = 0;
  localparam int IC2 = 1;
  localparam int KM  = 2;
  localparam int DM  = 3;
  localparam int DT  = 4;

  function automatic int bytes_per_word(input int n);
    return n / 8;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for a slow asynchronous pin, with rise/fall detection
// against a registered copy of the synchronised level.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= async_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;
  assign fall  = ~s2_q & prev_q;

endmodule

// File: rtl/dda_ctrl.sv
// Loader/sequencer for the posit DDA core: assembles five operands from a
// byte stream, commits them atomically, issues INIT, then paces steps.
module dda_ctrl
  import dda_pkg::*;
#(
  parameter int N        = 16,
  parameter int ES       = 2,
  parameter int STEP_DIV = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic             wr,
  input  logic             load_mode,
  input  logic             hold,
  output logic [N-1:0]     ic1,
  output logic [N-1:0]     ic2,
  output logic [N-1:0]     vK_M,
  output logic [N-1:0]     vD_M,
  output logic [N-1:0]     dt,
  output logic             dda_en,
  output logic             dda_rst_n,
  output logic             sample_valid,
  output logic             running,
  output logic [CNT_W-1:0] step_count
);

  localparam int BPW   = bytes_per_word(N);
  localparam int TOTAL = NUM_WORDS * BPW;
  localparam int SW    = TOTAL * 8;
  localparam int BCW   = $clog2(TOTAL);
  localparam int PW    = $clog2(STEP_DIV);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(TOTAL - 1);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(STEP_DIV - 1);

  if ((N % 8) != 0 || STEP_DIV < 2 || ES < 0) begin : g_param_check
    $error("dda_ctrl: N must be a multiple of 8 and STEP_DIV at least 2");
  end

  logic wr_level, wr_rise, wr_fall;
  logic load_level, load_rise, load_fall;

  sync_edge u_sync_wr (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (wr),
    .level    (wr_level),
    .rise     (wr_rise),
    .fall     (wr_fall)
  );

  sync_edge u_sync_load (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (load_mode),
    .level    (load_level),
    .rise     (load_rise),
    .fall     (load_fall)
  );

  logic unused_sync;
  assign unused_sync = wr_level ^ wr_fall ^ load_level;

  state_e            state_q, state_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [SW-1:0]     shadow_q, shadow_d;
  logic [N-1:0]      op_q [NUM_WORDS];
  logic [N-1:0]      op_d [NUM_WORDS];
  logic [N-1:0]      shadow_word [NUM_WORDS];
  logic [PW-1:0]     presc_q, presc_d;
  logic [CNT_W-1:0]  step_count_q, step_count_d;
  logic              dda_en_q, dda_en_d;
  logic              dda_rst_n_q, dda_rst_n_d;
  logic              sample_valid_q, sample_valid_d;

  // Byte 0 of the stream lands in the top byte of the shadow vector.
  always_comb begin
    shadow_d = shadow_q;
    if (state_q == LOAD && wr_rise) begin
      for (int i = 0; i < TOTAL; i++) begin
        if (byte_cnt_q == BCW'(i)) shadow_d[(TOTAL-1-i)*8 +: 8] = data_in;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
    assign shadow_word[gi] = shadow_d[(NUM_WORDS-1-gi)*N +: N];
  end

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    op_d           = op_q;
    presc_d        = presc_q;
    step_count_d   = step_count_q;
    dda_en_d       = 1'b0;
    dda_rst_n_d    = dda_rst_n_q;
    sample_valid_d = dda_en_q && (state_q == RUN);

    case (state_q)
      IDLE: begin
        if (load_rise) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
        end
      end
      LOAD: begin
        // Completion takes priority over a simultaneous abort.
        if (wr_rise && byte_cnt_q == LAST_BYTE) begin
          for (int w = 0; w < NUM_WORDS; w++) op_d[w] = shadow_word[w];
          state_d      = INIT;
          byte_cnt_d   = '0;
          dda_en_d     = 1'b1;
          dda_rst_n_d  = 1'b0;
          presc_d      = '0;
          step_count_d = '0;
        end else if (load_fall) begin
          state_d    = IDLE;
          byte_cnt_d = '0;
        end else if (wr_rise) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end
      INIT: begin
        state_d     = RUN;
        dda_rst_n_d = 1'b1;
        presc_d     = '0;
      end
      RUN: begin
        if (load_rise) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
        end else if (!hold) begin
          presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
          if (presc_d == PRESC_MAX) begin
            dda_en_d     = 1'b1;
            step_count_d = step_count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      byte_cnt_q     <= '0;
      shadow_q       <= '0;
      for (int i = 0; i < NUM_WORDS; i++) op_q[i] <= '0;
      presc_q        <= '0;
      step_count_q   <= '0;
      dda_en_q       <= 1'b0;
      dda_rst_n_q    <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      shadow_q       <= shadow_d;
      op_q           <= op_d;
      presc_q        <= presc_d;
      step_count_q   <= step_count_d;
      dda_en_q       <= dda_en_d;
      dda_rst_n_q    <= dda_rst_n_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign ic1          = op_q[IC1];
  assign ic2          = op_q[IC2];
  assign vK_M         = op_q[KM];
  assign vD_M         = op_q[DM];
  assign dt           = op_q[DT];
  assign dda_en       = dda_en_q;
  assign dda_rst_n    = dda_rst_n_q;
  assign sample_valid = sample_valid_q;
  assign running      = (state_q == RUN);
  assign step_count   = step_count_q;

endmodule

// File: tb/tb_dda_ctrl.sv
// Directed bench for dda_ctrl: load, INIT, pacing, hold, reload, abort and
// asynchronous reset, with hand-computed expected values.
module tb_dda_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        wr;
  logic        load_mode;
  logic        hold;
  logic [15:0] ic1, ic2, vK_M, vD_M, dt;
  logic        dda_en, dda_rst_n, sample_valid, running;
  logic [15:0] step_count;

  int n_cmp = 0;
  int n_bad = 0;
  int init_cnt = 0;

  dda_ctrl #(.N(16), .ES(2), .STEP_DIV(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .wr           (wr),
    .load_mode    (load_mode),
    .hold         (hold),
    .ic1          (ic1),
    .ic2          (ic2),
    .vK_M         (vK_M),
    .vD_M         (vD_M),
    .dt           (dt),
    .dda_en       (dda_en),
    .dda_rst_n    (dda_rst_n),
    .sample_valid (sample_valid),
    .running      (running),
    .step_count   (step_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && dda_en && !dda_rst_n) init_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds wr high for 3 clocks then low for 3; returns early on an INIT cycle.
  task automatic send_byte(input logic [7:0] b, output bit got_init);
    got_init = 1'b0;
    data_in  = b;
    wr       = 1'b1;
    $display("tx byte %02h", b);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) wr = 1'b0;
      if (dda_en && !dda_rst_n) begin
        got_init = 1'b1;
        break;
      end
    end
    wr = 1'b0;
  endtask

  task automatic load_bytes(input logic [79:0] v, input int nbytes, output bit got_init);
    bit g;
    g = 1'b0;
    for (int i = 0; i < nbytes; i++) send_byte(v[79-8*i -: 8], g);
    got_init = g;
  endtask

  task automatic raise_load();
    load_mode = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit got;
    int n_en, first_en, prev_en, gap_bad, held_en, wait_n, late_en, init_before;

    rst_n = 1'b0; data_in = 8'h00; wr = 1'b0; load_mode = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en", dda_en, 0);
    chk("rst_rstn", dda_rst_n, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_running", running, 0);
    chk("rst_steps", step_count, 0);
    chk("rst_ic1", ic1, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // First load and INIT
    raise_load();
    load_bytes(80'h4000_0000_4000_3800_2800, 10, got);
    chk("init_seen", got, 1);
    chk("init_en", dda_en, 1);
    chk("init_rstn", dda_rst_n, 0);
    chk("init_running", running, 0);
    chk("ic1", ic1, 16'h4000);
    chk("ic2", ic2, 16'h0000);
    chk("vK_M", vK_M, 16'h4000);
    chk("vD_M", vD_M, 16'h3800);
    chk("dt", dt, 16'h2800);

    // Pacing over 20 RUN cycles
    n_en = 0; first_en = -1; prev_en = -1; gap_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("run_rstn", dda_rst_n, 1);
        chk("run_running", running, 1);
        chk("run_en0", dda_en, 0);
      end
      if (k == 4) chk("sv_before", sample_valid, 0);
      if (k == 5) chk("sv_first", sample_valid, 1);
      if (dda_en) begin
        if (first_en < 0) first_en = k;
        else if (k - prev_en != 4) gap_bad++;
        prev_en = k;
        n_en++;
      end
    end
    chk("first_en_offset", first_en, 4);
    chk("en_pulses", n_en, 5);
    chk("en_spacing", gap_bad, 0);
    chk("steps_20", step_count, 5);

    // Hold mid-count: prescaler frozen at 1, two cycles remain after release
    repeat (2) @(negedge clk);
    hold = 1'b1;
    held_en = 0;
    repeat (10) begin
      @(negedge clk);
      held_en += int'(dda_en);
    end
    hold = 1'b0;
    wait_n = 0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (dda_en) begin
        wait_n = j;
        break;
      end
    end
    chk("hold_no_en", held_en, 0);
    chk("hold_resume", wait_n, 2);
    chk("steps_hold", step_count, 6);

    // Reload during RUN
    load_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("run_ignores_fall", running, 1);
    load_mode = 1'b1;
    repeat (3) @(negedge clk);
    late_en = 0;
    repeat (10) begin
      @(negedge clk);
      late_en += int'(dda_en);
    end
    chk("reload_en_stop", late_en, 0);
    chk("reload_running", running, 0);

    // Abort after 6 bytes
    init_before = init_cnt;
    load_bytes(80'h1111_2222_3333_4444_5555, 6, got);
    load_mode = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_ic1", ic1, 16'h4000);
    chk("abort_vD_M", vD_M, 16'h3800);
    chk("abort_no_init", init_cnt, init_before);
    chk("abort_running", running, 0);

    // Stray byte in IDLE, then a fresh load with atomic commit
    send_byte(8'hFF, got);
    raise_load();
    load_bytes(80'h1234_5678_9ABC_DEF0_0FED, 9, got);
    chk("atomic_ic1", ic1, 16'h4000);
    chk("atomic_dt", dt, 16'h2800);
    send_byte(8'hED, got);
    chk("init2_seen", got, 1);
    chk("init2_steps", step_count, 0);
    chk("ic1_2", ic1, 16'h1234);
    chk("ic2_2", ic2, 16'h5678);
    chk("vK_M_2", vK_M, 16'h9ABC);
    chk("vD_M_2", vD_M, 16'hDEF0);
    chk("dt_2", dt, 16'h0FED);

    // Asynchronous reset in the middle of a load
    load_mode = 1'b0;
    repeat (3) @(negedge clk);
    raise_load();
    load_bytes(80'hA5A5_0001_0002_0003_0004, 3, got);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ic1", ic1, 0);
    chk("arst_dt", dt, 0);
    chk("arst_steps", step_count, 0);
    chk("arst_en", dda_en, 0);
    load_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'hFF, got);
    chk("post_rst_running", running, 0);
    chk("post_rst_ic1", ic1, 0);
    raise_load();
    load_bytes(80'hA5A5_0001_0002_0003_0004, 10, got);
    chk("init3_seen", got, 1);
    chk("ic1_3", ic1, 16'hA5A5);
    chk("dt_3", dt, 16'h0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
